// File: rtl/moving_avg_filter.sv
// Streaming boxcar filter: running-sum accumulator over a circular sample buffer,
// window 2^k selectable at run time, valid/ready input and single-cycle output strobe.
module moving_avg_filter #(
  parameter int unsigned BIT_WIDTH  = 16,
  parameter int unsigned LOG2_DEPTH = 4,
  parameter bit          SIGNED     = 1'b0
) (
  input  logic                 clk,
  input  logic                 sclr,
  input  logic [2:0]           filt_sel,
  input  logic [BIT_WIDTH-1:0] d,
  input  logic                 d_valid,
  output logic                 in_ready,
  output logic [BIT_WIDTH-1:0] q,
  output logic                 q_valid,
  output logic                 primed
);

  localparam int unsigned Depth = 1 << LOG2_DEPTH;
  localparam int unsigned AccW  = BIT_WIDTH + LOG2_DEPTH;
  localparam int unsigned CntW  = LOG2_DEPTH + 1;
  localparam logic [2:0]  KMax  = 3'(LOG2_DEPTH);

  typedef enum logic [1:0] {StFlush, StFill, StRun} state_e;

  state_e                state_q, state_d;
  logic [2:0]            k_q, k_sel;
  logic [CntW-1:0]       count_q, count_d, n_win;
  logic [LOG2_DEPTH-1:0] wr_ptr_q, rd_ptr;
  logic [AccW-1:0]       acc_q, ext_d, ext_old;
  logic [BIT_WIDTH-1:0]  buf_mem [Depth];
  logic                  accept, full, out_pend_q;

  always_comb begin
    k_sel   = (filt_sel > KMax) ? KMax : filt_sel;
    n_win   = CntW'(1) << k_q;
    full    = (count_q == n_win);
    accept  = d_valid && in_ready;
    // n_win == Depth wraps to 0, which correctly points at the oldest entry
    rd_ptr  = wr_ptr_q - n_win[LOG2_DEPTH-1:0];
    ext_d   = {{LOG2_DEPTH{SIGNED && d[BIT_WIDTH-1]}}, d};
    ext_old = full ? {{LOG2_DEPTH{SIGNED && buf_mem[rd_ptr][BIT_WIDTH-1]}}, buf_mem[rd_ptr]}
                   : '0;
    count_d = full ? count_q : count_q + CntW'(1);
  end

  // State register
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      state_q <= StFlush;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFlush: state_d = StFill;
      StFill: begin
        if (k_sel != k_q) begin
          state_d = StFlush;
        end else if (accept && (count_d == n_win)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (k_sel != k_q) begin
          state_d = StFlush;
        end
      end
      default: state_d = StFlush;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q != StFlush) && (k_sel == k_q);
    primed   = (state_q == StRun);
  end

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      acc_q      <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      k_q        <= '0;
      q          <= '0;
      q_valid    <= 1'b0;
      out_pend_q <= 1'b0;
    end else begin
      q_valid    <= out_pend_q;
      // k_q cannot change on the edge after an accept, so the slice is still the right one
      if (out_pend_q) begin
        q <= acc_q[k_q +: BIT_WIDTH];
      end
      out_pend_q <= accept && (count_d == n_win);
      if (state_q == StFlush) begin
        acc_q   <= '0;
        count_q <= '0;
        k_q     <= k_sel;
      end else if (accept) begin
        acc_q    <= acc_q + ext_d - ext_old;
        count_q  <= count_d;
        wr_ptr_q <= wr_ptr_q + LOG2_DEPTH'(1);
      end
    end
  end

  // Sample storage carries no reset; stale entries are never read before being overwritten
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_mem[wr_ptr_q] <= d;
    end
  end

endmodule

// File: doc/moving_avg_filter.md
# moving_avg_filter

Streaming boxcar (moving-average) filter: the parametrised successor to the fixed 16-tap filter block. Window length is run-time selectable as 2^k samples, up to 2^LOG2_DEPTH. Sample width and signedness are set by parameters. It uses a running-sum accumulator and a circular sample buffer instead of a full adder tree, and adds valid/ready handshaking. It sits between the sample source (ADC/PWM capture) and downstream DSP stages, and reports when its window is primed.

## Interface
- BIT_WIDTH, 16, sample width of d and q.
- LOG2_DEPTH, 4, log2 of maximum window; buffer holds 2^LOG2_DEPTH samples (1..6 supported).
- SIGNED, 0, 1 = two's-complement samples with arithmetic shift; 0 = unsigned.
- clk  in  1  single clock, rising edge.
- sclr  in  1  reset, asynchronous, active-high.
- filt_sel  in  3  window select k; window N = 2^k; values > LOG2_DEPTH clamp to LOG2_DEPTH.
- d  in  BIT_WIDTH  input sample.
- d_valid  in  1  sample strobe; sample accepted when d_valid && in_ready at a rising edge.
- in_ready  out  1  block accepts samples.
- q  out  BIT_WIDTH  averaged output; holds last value when q_valid low.
- q_valid  out  1  one-cycle pulse per new averaged output.
- primed  out  1  high while the window holds N valid samples.

## Operation
- State machine: FLUSH, FILL, RUN. Reset enters FLUSH with k_cur=0.
- FLUSH (1 cycle): acc<=0, count<=0, k_cur<=clamp(filt_sel). Next state is FILL. wr_ptr and buffer are not cleared; the buffer has no reset.
- in_ready = (state != FLUSH) && (clamp(filt_sel) == k_cur). Combinational.
- From FILL or RUN, clamp(filt_sel) != k_cur moves the block to FLUSH next edge. A sample offered that cycle is not accepted, because in_ready is low.
- On an accepted sample:
  - buf[wr_ptr]<=d and wr_ptr<=wr_ptr+1 (mod 2^LOG2_DEPTH).
  - acc<=acc+ext(d)-old, where old=ext(buf[(wr_ptr-N) mod depth]) if count==N, else 0.
  - count<=min(count+1,N).
- FILL→RUN when count reaches N. primed = (state==RUN).
- Accumulator width is BIT_WIDTH+LOG2_DEPTH. ext() is sign-extension if SIGNED, else zero-extension. The accumulator never overflows.
- Output is q<=acc[k_cur+BIT_WIDTH-1:k_cur]. This is floor division by N, rounding toward −∞ for signed.
- q_valid pulses only for samples accepted while primed, including the sample that completes the fill.
- N=1 (k=0) is passthrough with pipeline latency; primed after 1 sample.

## Timing
- Reset values: q=0, q_valid=0, primed=0, in_ready=0 (state FLUSH), acc=0, count=0, wr_ptr=0.
- Async assertion of sclr forces all of the above immediately, including mid-stream. After deassertion, the first edge executes FLUSH; in_ready is high from the following cycle.
- Latency: a sample accepted at edge E0 updates acc at E0. q and q_valid update at E1. The result is visible in the cycle after E1, so latency is 2 edges.
- Back-to-back d_valid every cycle is supported at full rate.
- A window change costs 1 FLUSH cycle plus N accepted samples before the next q_valid.
- A window change does not abort an in-flight output: a q_valid already scheduled at E1 still fires.

## Test plan
- Reset: sclr high mid-stream → q=0, q_valid=0, primed=0, in_ready=0 without a clock edge; after release, in_ready=1 from the 2nd cycle.
- Fill and steady state, SIGNED=0, filt_sel=2:
  - Feed 4,8,12,16 → single q_valid with q=10 after 16; primed rises.
  - Then feed 20 → q=14.
  - Then feed 0 → q=12.
- Passthrough, filt_sel=0: feed 0xFFFF then 0x0001 on consecutive cycles → q=0xFFFF then 0x0001, each 2 edges after acceptance.
- Width/overflow, filt_sel=4: feed 20 samples of 0xFFFF back-to-back → q=0xFFFF on every pulse from the 16th sample on.
- Signed rounding, SIGNED=1, filt_sel=1: feed -3, 0 → q=-2 (0xFFFE); then feed 5 → q=2.
- Window change mid-run, filt_sel 2→1 while d_valid held high:
  - in_ready low for the change cycle and the FLUSH cycle; those samples are dropped.
  - q_valid and primed stay low until 2 new samples are accepted; then q = their floored mean.
  - filt_sel=7 behaves as 4.
